// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two-port req/ack arbiter and strobe sequencer for the
// branch predictor's pattern history table, an async single-port SRAM.
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   a_req/a_we/a_addr/a_wdata     port A request (lookup); held until a_ack
//   a_ack, a_rdata                port A completion pulse and read data
//   b_*                           port B (update), same as port A
//   ram_cs_n/we_n/oe_n            active-low SRAM strobes
//   ram_addr, ram_data            SRAM address and tri-stated data bus
//   busy                          high whenever the sequencer is not idle
module ram_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic          ram_cs_n,
    output logic          ram_we_n,
    output logic          ram_oe_n,
    output logic [AW-1:0] ram_addr,
    inout  wire  [DW-1:0] ram_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    state_t        state;
    state_t        state_d;
    logic          grant;
    logic          grant_d;
    logic          take;
    logic          last_grant;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          active;
    logic          drive;

    // grant: 0 = port A, 1 = port B. On contention the port that did not
    // win last time is chosen, so the two arms are mutually exclusive.
    always_comb begin
        state_d = state;
        grant_d = grant;
        take    = 1'b0;
        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    (a_req && (!b_req || last_grant)): begin
                        grant_d = 1'b0;
                        take    = 1'b1;
                        state_d = SETUP;
                    end
                    (b_req && (!a_req || !last_grant)): begin
                        grant_d = 1'b1;
                        take    = 1'b1;
                        state_d = SETUP;
                    end
                    default: ;
                endcase
            end
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            a_rdata    <= '0;
            b_rdata    <= '0;
        end else begin
            state <= state_d;
            grant <= grant_d;
            if (take) begin
                lat_we    <= grant_d ? b_we    : a_we;
                lat_addr  <= grant_d ? b_addr  : a_addr;
                lat_wdata <= grant_d ? b_wdata : a_wdata;
            end
            // Read data is captured as OE is released, while the SRAM
            // output is still valid.
            if (state == ACCESS && !lat_we) begin
                if (grant) begin
                    b_rdata <= ram_data;
                end else begin
                    a_rdata <= ram_data;
                end
            end
            if (state == DONE) begin
                last_grant <= grant;
            end
        end
    end

    // Latched fields only change in IDLE, so address and data are stable
    // across SETUP/ACCESS/DONE around every strobe.
    assign active   = (state != IDLE);
    assign drive    = active && lat_we;
    assign busy     = active;
    assign ram_cs_n = !active;
    assign ram_we_n = !(state == ACCESS && lat_we);
    assign ram_oe_n = !(state == ACCESS && !lat_we);
    assign ram_addr = lat_addr;
    assign ram_data = drive ? lat_wdata : {DW{1'bz}};
    assign a_ack    = (state == DONE) && !grant;
    assign b_ack    = (state == DONE) && grant;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural async SRAM.
// Expected values are hand-derived; all comparisons go through check().
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a_req = 1'b0;
    logic       a_we = 1'b0;
    logic [7:0] a_addr = '0;
    logic [7:0] a_wdata = '0;
    logic       a_ack;
    logic [7:0] a_rdata;
    logic       b_req = 1'b0;
    logic       b_we = 1'b0;
    logic [7:0] b_addr = '0;
    logic [7:0] b_wdata = '0;
    logic       b_ack;
    logic [7:0] b_rdata;
    logic       ram_cs_n;
    logic       ram_we_n;
    logic       ram_oe_n;
    logic [7:0] ram_addr;
    wire  [7:0] ram_data;
    logic       busy;

    logic [7:0] mem [256];
    logic       probe_en = 1'b0;
    int         errors = 0;
    int         checks = 0;
    int         contention = 0;
    int         we_lo = 0;
    int         oe_lo = 0;

    ram_port_arbiter #(.AW(8), .DW(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_ack    (a_ack),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_ack    (b_ack),
        .b_rdata  (b_rdata),
        .ram_cs_n (ram_cs_n),
        .ram_we_n (ram_we_n),
        .ram_oe_n (ram_oe_n),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // SRAM output drive, plus a probe driver used only while all strobes
    // are high: the bus reads back the probe value only if the DUT is off.
    assign ram_data = (ram_cs_n === 1'b0 && ram_oe_n === 1'b0 &&
                       ram_we_n === 1'b1) ? mem[ram_addr] : 8'hzz;
    assign ram_data = probe_en ? 8'hC3 : 8'hzz;

    always @(posedge ram_we_n) begin
        if (ram_cs_n === 1'b0) begin
            mem[ram_addr] <= ram_data;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_oe_n === 1'b0 &&
                (ram_we_n === 1'b0 || ram_data !== mem[ram_addr])) begin
                contention <= contention + 1;
            end
            if (ram_we_n === 1'b0) we_lo <= we_lo + 1;
            if (ram_oe_n === 1'b0) oe_lo <= oe_lo + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input bit p, input bit we, input logic [7:0] ad,
                        input logic [7:0] wd, output logic [7:0] rd,
                        output int cyc);
        @(negedge clk);
        if (!p) begin
            a_req = 1'b1; a_we = we; a_addr = ad; a_wdata = wd;
        end else begin
            b_req = 1'b1; b_we = we; b_addr = ad; b_wdata = wd;
        end
        cyc = 0;
        rd  = 'x;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((!p && a_ack) || (p && b_ack)) begin
                cyc = i;
                rd  = p ? b_rdata : a_rdata;
                break;
            end
        end
        if (!p) a_req = 1'b0;
        else    b_req = 1'b0;
        if (cyc == 0) check("xfer_timeout", 0, 1);
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] exp;
        int         cyc;
        int         n;
        int         acks;
        bit         ports [4];
        int         cycs [4];
        logic [7:0] brd [4];

        // Reset values
        probe_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs_n", ram_cs_n, 1);
        check("rst_we_n", ram_we_n, 1);
        check("rst_oe_n", ram_oe_n, 1);
        check("rst_addr", ram_addr, 0);
        check("rst_bus_z", ram_data, 8'hC3);
        check("rst_acks", {a_ack, b_ack}, 0);
        check("rst_rdata", {a_rdata, b_rdata}, 0);
        check("rst_busy", busy, 0);
        probe_en = 1'b0;
        rst_n = 1'b1;

        // Single write from port A
        @(negedge clk);
        we_lo = 0; oe_lo = 0; contention = 0;
        xfer(0, 1, 8'h10, 8'hAA, rd, cyc);
        check("wr_latency", cyc, 3);
        @(posedge clk); #1;
        check("wr_we_lo", we_lo, 1);
        check("wr_oe_lo", oe_lo, 0);
        check("wr_mem", mem[8'h10], 8'hAA);
        check("wr_contention", contention, 0);

        // Cross-port read from port B
        we_lo = 0; oe_lo = 0;
        xfer(1, 0, 8'h10, 8'h00, rd, cyc);
        check("rd_latency", cyc, 3);
        check("rd_b_rdata", rd, 8'hAA);
        check("rd_a_rdata", a_rdata, 0);
        @(posedge clk); #1;
        check("rd_oe_lo", oe_lo, 1);
        check("rd_we_lo", we_lo, 0);

        // Contention: A writes 0x40, B reads 0x10, both held high
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h40; a_wdata = 8'h01;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h10; b_wdata = 8'h00;
        n = 0;
        for (int i = 1; i <= 30 && n < 4; i++) begin
            @(negedge clk);
            if (a_ack && b_ack) check("cont_both_ack", 1, 0);
            if (a_ack || b_ack) begin
                ports[n] = b_ack;
                cycs[n]  = i;
                brd[n]   = b_rdata;
                n++;
                if (n == 4) begin
                    a_req = 1'b0;
                    b_req = 1'b0;
                end
            end
        end
        a_req = 1'b0;
        b_req = 1'b0;
        check("cont_count", n, 4);
        for (int k = 0; k < n; k++) begin
            check($sformatf("cont_port%0d", k), ports[k], k % 2);
            check($sformatf("cont_cyc%0d", k), cycs[k], 3 + 4 * k);
            if (ports[k]) check($sformatf("cont_rd%0d", k), brd[k], 8'hAA);
        end
        check("cont_mem", mem[8'h40], 8'h01);

        // Full sweep: A writes all, B reads all back, then 0x00 again
        for (int i = 0; i < 256; i++) begin
            exp = i[0] ? 8'h55 : 8'hAA;
            xfer(0, 1, 8'(i), exp, rd, cyc);
        end
        for (int i = 0; i <= 256; i++) begin
            exp = i[0] ? 8'h55 : 8'hAA;
            xfer(1, 0, 8'(i), 8'h00, rd, cyc);
            check($sformatf("sweep_%0d", i), rd, exp);
        end
        check("sweep_contention", contention, 0);

        // Reset during the ACCESS cycle of a write to 0x20
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_wdata = 8'h77;
        repeat (2) @(negedge clk);
        check("mid_we_lo", ram_we_n, 0);
        rst_n = 1'b0;
        a_req = 1'b0;
        #1;
        probe_en = 1'b1;
        #1;
        check("mid_cs_n", ram_cs_n, 1);
        check("mid_we_n", ram_we_n, 1);
        check("mid_oe_n", ram_oe_n, 1);
        check("mid_bus_z", ram_data, 8'hC3);
        check("mid_busy", busy, 0);
        check("mid_b_rdata", b_rdata, 0);
        probe_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_ack || b_ack) acks++;
        end
        check("mid_no_ack", acks, 0);
        xfer(0, 1, 8'h20, 8'h78, rd, cyc);
        check("retry_latency", cyc, 3);
        @(posedge clk); #1;
        check("retry_mem", mem[8'h20], 8'h78);
        check("final_contention", contention, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
